// File: rtl/alu_uart_sequencer_if.sv
// Byte/handshake bundle between the UART pair, the ALU and the frame sequencer.
// master = UART/ALU environment side, slave = sequencer side.
interface alu_uart_sequencer_if #(
    parameter int NBIT_DATA_LEN = 8,
    parameter int NBIT_OP       = 6
);
    logic                     rx_done_tick;
    logic [NBIT_DATA_LEN-1:0] rx_data_in;
    logic [NBIT_DATA_LEN-1:0] alu_data_in;
    logic                     tx_done_tick;
    logic [NBIT_DATA_LEN-1:0] A;
    logic [NBIT_DATA_LEN-1:0] B;
    logic [NBIT_OP-1:0]       Op;
    logic [NBIT_DATA_LEN-1:0] data_out;
    logic                     tx_start;
    logic                     busy;
    logic                     err_op;
    logic                     err_timeout;
    logic                     rx_overrun;

    modport master (
        output rx_done_tick, rx_data_in, alu_data_in, tx_done_tick,
        input  A, B, Op, data_out, tx_start, busy, err_op, err_timeout, rx_overrun
    );

    modport slave (
        input  rx_done_tick, rx_data_in, alu_data_in, tx_done_tick,
        output A, B, Op, data_out, tx_start, busy, err_op, err_timeout, rx_overrun
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// Frames A/B/opcode RX bytes into the ALU and returns the result to TX; tx_start 2 cycles after the opcode byte.
// No backpressure on RX: bytes arriving while a result is in flight are dropped and flagged as overrun.
module alu_uart_sequencer #(
    parameter int NBIT_DATA_LEN  = 8,
    parameter int NBIT_OP        = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_uart_sequencer_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [NBIT_OP-1:0] OP_ADD = NBIT_OP'(6'b100000);
    localparam logic [NBIT_OP-1:0] OP_SUB = NBIT_OP'(6'b100010);
    localparam logic [NBIT_OP-1:0] OP_AND = NBIT_OP'(6'b100100);
    localparam logic [NBIT_OP-1:0] OP_OR  = NBIT_OP'(6'b100101);
    localparam logic [NBIT_OP-1:0] OP_XOR = NBIT_OP'(6'b100110);
    localparam logic [NBIT_OP-1:0] OP_NOR = NBIT_OP'(6'b100111);
    localparam logic [NBIT_OP-1:0] OP_SRA = NBIT_OP'(6'b000011);
    localparam logic [NBIT_OP-1:0] OP_SRL = NBIT_OP'(6'b000010);

    typedef enum logic [2:0] {
        S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [NBIT_DATA_LEN-1:0] r_a, r_b, r_dout;
    logic [NBIT_DATA_LEN-1:0] w_a_nxt, w_b_nxt, w_dout_nxt;
    logic [NBIT_OP-1:0]       r_op, w_op_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic                     r_tx_start, r_busy, r_err_op, r_err_to, r_ovr;
    logic                     w_tx_start_nxt, w_busy_nxt, w_err_op_nxt, w_err_to_nxt, w_ovr_nxt;
    logic [NBIT_OP-1:0]       w_rx_op;
    logic                     w_op_valid;
    logic                     w_expire;

    assign w_rx_op  = bus.rx_data_in[NBIT_OP-1:0];
    assign w_expire = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);

    always_comb begin
        case (w_rx_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: w_op_valid = 1'b1;
            default:                        w_op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_WAIT_A;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_A:  if (bus.rx_done_tick) w_state_nxt = S_WAIT_B;
            S_WAIT_B: begin
                if (bus.rx_done_tick) w_state_nxt = S_WAIT_OP;
                else if (w_expire)    w_state_nxt = S_WAIT_A;
            end
            S_WAIT_OP: begin
                if (bus.rx_done_tick) w_state_nxt = w_op_valid ? S_EXEC : S_WAIT_A;
                else if (w_expire)    w_state_nxt = S_WAIT_A;
            end
            S_EXEC:    w_state_nxt = S_SEND;
            S_SEND:    w_state_nxt = S_WAIT_TX;
            S_WAIT_TX: if (bus.tx_done_tick) w_state_nxt = S_WAIT_A;
            default:   w_state_nxt = S_WAIT_A;
        endcase
    end

    // Next values of the registered outputs; a tick in the expiry cycle takes priority over the timeout.
    always_comb begin
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_dout_nxt   = r_dout;
        w_cnt_nxt    = '0;
        w_err_op_nxt = 1'b0;
        w_err_to_nxt = 1'b0;
        w_ovr_nxt    = 1'b0;
        case (r_state)
            S_WAIT_A: if (bus.rx_done_tick) w_a_nxt = bus.rx_data_in;
            S_WAIT_B, S_WAIT_OP: begin
                if (bus.rx_done_tick) begin
                    if (r_state == S_WAIT_B) w_b_nxt = bus.rx_data_in;
                    else if (w_op_valid)     w_op_nxt = w_rx_op;
                    else                     w_err_op_nxt = 1'b1;
                end else if (w_expire) begin
                    w_err_to_nxt = 1'b1;
                end else if (TIMEOUT_CYCLES > 0) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_EXEC: begin
                w_dout_nxt = bus.alu_data_in;
                w_ovr_nxt  = bus.rx_done_tick;
            end
            default:  w_ovr_nxt = bus.rx_done_tick;
        endcase
        w_tx_start_nxt = (w_state_nxt == S_SEND);
        w_busy_nxt     = (w_state_nxt != S_WAIT_A);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_dout     <= '0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_err_op   <= 1'b0;
            r_err_to   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_op       <= w_op_nxt;
            r_dout     <= w_dout_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_busy     <= w_busy_nxt;
            r_err_op   <= w_err_op_nxt;
            r_err_to   <= w_err_to_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.Op          = r_op;
    assign bus.data_out    = r_dout;
    assign bus.tx_start    = r_tx_start;
    assign bus.busy        = r_busy;
    assign bus.err_op      = r_err_op;
    assign bus.err_timeout = r_err_to;
    assign bus.rx_overrun  = r_ovr;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed, table-driven bench for alu_uart_sequencer with a small behavioural ALU.
module tb_alu_uart_sequencer;
    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;

    alu_uart_sequencer_if #(.NBIT_DATA_LEN(8), .NBIT_OP(6)) bus ();

    alu_uart_sequencer #(
        .NBIT_DATA_LEN (8),
        .NBIT_OP       (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; shifts move operand A by one bit position.
    always_comb begin
        case (bus.Op)
            6'b100000: bus.alu_data_in = bus.A + bus.B;
            6'b100010: bus.alu_data_in = bus.A - bus.B;
            6'b100100: bus.alu_data_in = bus.A & bus.B;
            6'b100101: bus.alu_data_in = bus.A | bus.B;
            6'b100110: bus.alu_data_in = bus.A ^ bus.B;
            6'b100111: bus.alu_data_in = ~(bus.A | bus.B);
            6'b000011: bus.alu_data_in = {bus.A[7], bus.A[7:1]};
            6'b000010: bus.alu_data_in = {1'b0, bus.A[7:1]};
            default:   bus.alu_data_in = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        bit         err;
        logic [7:0] dout;
    } vec_t;

    vec_t       vecs[11];
    logic [5:0] exp_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one byte so it is sampled at the next edge; returns 1 time unit after that edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_in   = b;
        bus.rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic tx_finish();
        idle(2);
        bus.tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_done_tick = 1'b0;
        chk("busy_after_tx_done", bus.busy, 1'b0);
    endtask

    task automatic frame_body(input vec_t v);
        send_byte(v.a);
        chk("busy_after_a", bus.busy, 1'b1);
        idle(1);
        send_byte(v.b);
        send_byte(v.op);
        if (v.err) begin
            chk("err_op_pulse", bus.err_op, 1'b1);
            chk("busy_after_err", bus.busy, 1'b0);
            chk("op_unchanged", bus.Op, exp_op);
            idle(1);
            chk("err_op_single", bus.err_op, 1'b0);
            chk("no_tx_on_err", bus.tx_start, 1'b0);
            idle(1);
            chk("no_tx_on_err2", bus.tx_start, 1'b0);
        end else begin
            exp_op = v.op[5:0];
            chk("reg_a", bus.A, v.a);
            chk("reg_b", bus.B, v.b);
            chk("reg_op", bus.Op, exp_op);
            chk("tx_start_exec", bus.tx_start, 1'b0);
            idle(1);
            chk("tx_start_send", bus.tx_start, 1'b1);
            chk("data_out", bus.data_out, v.dout);
            idle(1);
            chk("tx_start_single", bus.tx_start, 1'b0);
            chk("busy_wait_tx", bus.busy, 1'b1);
        end
    endtask

    task automatic wait_timeout(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            if (bus.err_timeout === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int   n;
        vec_t v;
        n_pass  = 0;
        n_total = 0;
        exp_op  = 6'h00;

        vecs[0]  = '{8'h05, 8'h03, 8'h20, 1'b0, 8'h08};
        vecs[1]  = '{8'h0F, 8'h01, 8'h3F, 1'b1, 8'h00};
        vecs[2]  = '{8'h10, 8'h01, 8'h22, 1'b0, 8'h0F};
        vecs[3]  = '{8'h80, 8'h00, 8'h02, 1'b0, 8'h40};
        vecs[4]  = '{8'hF0, 8'h3C, 8'h24, 1'b0, 8'h30};
        vecs[5]  = '{8'hF0, 8'h0F, 8'h25, 1'b0, 8'hFF};
        vecs[6]  = '{8'hFF, 8'h0F, 8'h26, 1'b0, 8'hF0};
        vecs[7]  = '{8'hF0, 8'h0F, 8'h27, 1'b0, 8'h00};
        vecs[8]  = '{8'h80, 8'h00, 8'h03, 1'b0, 8'hC0};
        vecs[9]  = '{8'h01, 8'h02, 8'hE0, 1'b0, 8'h03};
        vecs[10] = '{8'h01, 8'h02, 8'h21, 1'b1, 8'h00};

        reset_n          = 1'b0;
        bus.rx_done_tick = 1'b0;
        bus.rx_data_in   = 8'h00;
        bus.tx_done_tick = 1'b0;
        idle(3);
        chk("rst_A", bus.A, 8'h00);
        chk("rst_Op", bus.Op, 6'h00);
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pulses", {bus.tx_start, bus.err_op, bus.err_timeout, bus.rx_overrun}, 4'h0);
        reset_n = 1'b1;
        idle(2);

        // Invalid opcode straight out of reset leaves Op at zero, then the vector table.
        frame_body(vecs[1]);
        for (int i = 0; i < 11; i++) begin
            frame_body(vecs[i]);
            if (!vecs[i].err) tx_finish();
        end

        // Timeout in WAIT_B after a lone A byte, then a full frame.
        send_byte(8'hAA);
        wait_timeout(n);
        chk("timeout_wait_b_cycles", n, 16);
        chk("timeout_busy", bus.busy, 1'b0);
        chk("timeout_keeps_a", bus.A, 8'hAA);
        idle(1);
        chk("timeout_single", bus.err_timeout, 1'b0);
        v = '{8'h07, 8'h02, 8'h20, 1'b0, 8'h09};
        frame_body(v);
        tx_finish();

        // Timeout in WAIT_OP keeps B.
        send_byte(8'h21);
        send_byte(8'h43);
        wait_timeout(n);
        chk("timeout_wait_op_cycles", n, 16);
        chk("timeout_keeps_b", bus.B, 8'h43);

        // Byte arriving in the expiry cycle wins over the timeout.
        idle(1);
        send_byte(8'h11);
        idle(15);
        send_byte(8'h22);
        chk("expiry_tick_no_timeout", bus.err_timeout, 1'b0);
        chk("expiry_tick_b", bus.B, 8'h22);
        chk("expiry_tick_busy", bus.busy, 1'b1);
        send_byte(8'h20);
        idle(1);
        chk("expiry_tick_tx_start", bus.tx_start, 1'b1);
        chk("expiry_tick_data", bus.data_out, 8'h33);
        tx_finish();

        // RX byte during WAIT_TX is dropped and flagged.
        v = '{8'h33, 8'h11, 8'h22, 1'b0, 8'h22};
        frame_body(v);
        send_byte(8'h77);
        chk("overrun_pulse", bus.rx_overrun, 1'b1);
        chk("overrun_keeps_a", bus.A, 8'h33);
        chk("overrun_keeps_op", bus.Op, 6'h22);
        idle(1);
        chk("overrun_single", bus.rx_overrun, 1'b0);
        tx_finish();
        v = '{8'h0C, 8'h0A, 8'h26, 1'b0, 8'h06};
        frame_body(v);
        tx_finish();

        // Asynchronous reset mid-frame, between clock edges.
        send_byte(8'h01);
        send_byte(8'h02);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_A", bus.A, 8'h00);
        chk("async_rst_B", bus.B, 8'h00);
        chk("async_rst_Op", bus.Op, 6'h00);
        chk("async_rst_data_out", bus.data_out, 8'h00);
        chk("async_rst_busy", bus.busy, 1'b0);
        idle(2);
        reset_n = 1'b1;
        exp_op  = 6'h00;
        idle(2);
        chk("post_rst_busy", bus.busy, 1'b0);
        frame_body(vecs[0]);
        tx_finish();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
